buffer_rr_arbiter: RTL and testbench
====================================

Name: buffer_rr_arbiter

Overview:
- Round-robin scheduler that drains N_IN independent read-side buffer interfaces (full/data/delete) into one output word stream.
- Each input uses the same read-side handshake as our flow buffers:
  - in_full[i] and the in_data slice describe the current head word.
  - Pulsing in_delete[i] pops that word.
- Sits between per-channel buffers and a shared downstream stage (e.g. one FFT or filter core). Tags each output word with its source index.

Parameters:
- N_IN, 4, number of requesting buffers (≥2).
- WIDTH, 32, data word width.
- BURST, 4, max words popped from one input per grant (≥1).
- LOG_N, clog2(N_IN) derived localparam, width of index fields.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- in_full  input  N_IN  head word valid, per input.
- in_data  input  N_IN*WIDTH  head words packed; input i at [i*WIDTH +: WIDTH].
- in_delete  output  N_IN  pop strobe, per input (combinational, one-hot or zero).
- out_ready  input  1  downstream can take a word this cycle.
- out_nd  output  1  out_data/out_src valid (one-cycle strobe).
- out_data  output  WIDTH  registered output word.
- out_src  output  LOG_N  source input index of out_data.
- grant_active  output  1  high while in SERVE.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, ptr=0, grant=0, count=0.
  - out_nd=0, out_data=0, out_src=0, grant_active=0.
  - in_delete=0 whenever state=IDLE, so also 0 during/after reset.
  - Reset mid-burst abandons the burst; no further pops.
- State IDLE:
  - If any in_full: grant <= first index i, searching ptr, ptr+1, ..., wrapping mod N_IN, with in_full[i]=1.
  - Also count<=0, state<=SERVE.
  - Else stay in IDLE.
  - Costs exactly one arbitration cycle per grant; no pop in IDLE.
- State SERVE, pop condition: pop = out_ready & in_full[grant].
  - in_delete[grant] = pop, combinational in the same cycle.
  - All other in_delete bits are 0.
- On pop:
  - Next cycle: out_nd=1, out_data=in_data slice of grant (sampled at this edge), out_src=grant.
  - count<=count+1.
  - Latency: pop cycle to out_nd is 1 cycle.
  - out_nd=0 on every cycle following a non-pop cycle.
- Leave SERVE (state<=IDLE, ptr<=grant+1 mod N_IN) at the end of a cycle where either:
  - pop and count==BURST-1 (burst exhausted), or
  - in_full[grant]=0 (grantee ran dry; no pop that cycle).
- out_ready=0 in SERVE:
  - Stall, no pop, count held, grant held (even if in_full[grant] stays 1).
  - If in_full[grant]=0 the release rule still applies.
- Relies on inputs presenting the next head word combinationally after a pop. Back-to-back pops from one input every cycle are legal.
- Wrap-around:
  - ptr and the search index wrap from N_IN-1 to 0.
  - Non-power-of-two N_IN must wrap correctly (no out-of-range index).
- Fairness: a continuously-full input waits at most (N_IN-1)*(BURST+1) cycles plus out_ready stalls.

Optional Feature:
- Macro BUFFER_RR_ARBITER_FIXED_PRIO_EN.
- Defined:
  - IDLE search always starts at index 0 (lowest index wins).
  - ptr is not updated.
  - BURST and release rules unchanged.
- Undefined: round-robin search from ptr as above.
- Ports identical in both builds.

Test Plan:
- Reset, hold all in_full=0, out_ready=1 for 10 cycles -> out_nd, in_delete, grant_active stay 0; state IDLE.
- N_IN=4, BURST=4, only input 2 full with 6 words 0xA0..0xA5, out_ready=1:
  - out_nd words 0xA0-0xA3 on 4 consecutive cycles with out_src=2.
  - 1 IDLE cycle, then 0xA4, 0xA5.
  - Input 2 releases when empty.
- All 4 inputs continuously full, BURST=2 -> grant order 0,0,1,1,2,2,3,3,0,0..., one idle gap between groups. With FIXED_PRIO_EN: only input 0 served.
- Grant on input 1, toggle out_ready 1,0,0,1 -> in_delete[1] only on ready cycles; 2 words out, count unaffected by stalls, no word lost or duplicated.
- Input 3 has 1 word, inputs 0 and 1 full, ptr=3 -> serve input 3 once, release on empty, then input 0 (wrap), then input 1.
- Assert rst_n=0 for 1 cycle mid-burst on input 1 -> next cycle out_nd=0, in_delete=0, ptr=0; after release, arbitration restarts from input 0.

Source files
------------

// File: rtl/buffer_rr_arbiter.sv
// Round-robin scheduler draining N_IN read-side flow buffers into one tagged word stream.
// Define BUFFER_RR_ARBITER_FIXED_PRIO_EN to make every arbitration start at index 0.
module buffer_rr_arbiter #(
    parameter int N_IN  = 4,
    parameter int WIDTH = 32,
    parameter int BURST = 4,
    localparam int LOG_N = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_IN-1:0]         in_full,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    output logic [N_IN-1:0]         in_delete,
    input  logic                    out_ready,
    output logic                    out_nd,
    output logic [WIDTH-1:0]        out_data,
    output logic [LOG_N-1:0]        out_src,
    output logic                    grant_active
);

    localparam int CNT_W = $clog2(BURST + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SERVE = 1'b1;

    logic [0:0]       state_r;
    logic [LOG_N-1:0] ptr_r;
    logic [LOG_N-1:0] grant_r;
    logic [CNT_W-1:0] count_r;
    logic             out_nd_r;
    logic [WIDTH-1:0] out_data_r;
    logic [LOG_N-1:0] out_src_r;

    logic [LOG_N-1:0] search_base_s;
    logic [LOG_N-1:0] next_idx_s;
    logic             found_s;
    logic             pop_s;
    logic             grant_full_s;
    logic             last_word_s;
    logic [LOG_N-1:0] grant_inc_s;
    logic [WIDTH-1:0] grant_data_s;

`ifdef BUFFER_RR_ARBITER_FIXED_PRIO_EN
    assign search_base_s = '0;
`else
    assign search_base_s = ptr_r;
`endif

    // First full input at or after the search base, wrapping; later offsets are overwritten by earlier ones.
    always_comb begin
        int idx_v;
        found_s    = 1'b0;
        next_idx_s = '0;
        idx_v      = 0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            idx_v = int'(search_base_s) + k;
            if (idx_v >= N_IN) begin
                idx_v = idx_v - N_IN;
            end else begin
                idx_v = idx_v;
            end
            if (in_full[idx_v]) begin
                found_s    = 1'b1;
                next_idx_s = LOG_N'(idx_v);
            end else begin
                found_s    = found_s;
            end
        end
    end

    assign grant_full_s = in_full[grant_r];
    assign grant_data_s = in_data[grant_r*WIDTH +: WIDTH];
    // Reset gating keeps a mid-burst reset from popping a word that would never be emitted.
    assign pop_s        = rst_n & (state_r == ST_SERVE) & out_ready & grant_full_s;
    assign last_word_s  = (count_r == CNT_W'(BURST - 1));
    assign grant_inc_s  = (grant_r == LOG_N'(N_IN - 1)) ? '0 : grant_r + LOG_N'(1);

    // Pop strobe goes back to the granted buffer in the same cycle.
    always_comb begin
        in_delete = '0;
        if (pop_s) begin
            in_delete[grant_r] = 1'b1;
        end else begin
            in_delete = '0;
        end
    end

    // Arbitration state, burst counting and the registered output word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= '0;
            grant_r    <= '0;
            count_r    <= '0;
            out_nd_r   <= 1'b0;
            out_data_r <= '0;
            out_src_r  <= '0;
        end else begin
            out_nd_r <= pop_s;
            if (pop_s) begin
                out_data_r <= grant_data_s;
                out_src_r  <= grant_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        grant_r <= next_idx_s;
                        count_r <= '0;
                        state_r <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (!grant_full_s || (pop_s && last_word_s)) begin
                        state_r <= ST_IDLE;
`ifndef BUFFER_RR_ARBITER_FIXED_PRIO_EN
                        ptr_r   <= grant_inc_s;
`endif
                    end else if (pop_s) begin
                        count_r <= count_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_nd       = out_nd_r;
    assign out_data     = out_data_r;
    assign out_src      = out_src_r;
    assign grant_active = (state_r == ST_SERVE);

endmodule

// File: tb/tb_buffer_rr_arbiter.sv
// Scoreboard bench for buffer_rr_arbiter: emulated input buffers, cycle-level reference model, output monitor.
module tb_buffer_rr_arbiter;
    localparam int N     = 4;
    localparam int W     = 32;
    localparam int B     = 4;
    localparam int LN    = 2;
    localparam int DEPTH = 1024;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   in_full;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_delete;
    logic           out_ready = 1'b0;
    logic           out_nd;
    logic [W-1:0]   out_data;
    logic [LN-1:0]  out_src;
    logic           grant_active;

    buffer_rr_arbiter #(.N_IN(N), .WIDTH(W), .BURST(B)) dut (
        .clk(clk), .rst_n(rst_n), .in_full(in_full), .in_data(in_data),
        .in_delete(in_delete), .out_ready(out_ready), .out_nd(out_nd),
        .out_data(out_data), .out_src(out_src), .grant_active(grant_active)
    );

    always #5 clk = ~clk;

    // Upstream buffers: word storage, head advanced by DUT pops, tail by stimulus.
    logic [W-1:0] mem [N][DEPTH];
    int head [N] = '{default: 0};
    int tail [N] = '{default: 0};
    logic [W-1:0] pend [N][$];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_full[i]        = (head[i] != tail[i]);
            in_data[i*W +: W] = mem[i][head[i]];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (in_delete[i]) head[i] <= head[i] + 1;
        end
    end

    typedef struct { int src; logic [W-1:0] data; } exp_t;
    exp_t sb [$];

    int  vectors = 0;
    int  errors  = 0;
    bit  mon_en  = 1'b0;

    // Reference model: which buffer is being served, how many words it has given, where the next search starts.
    bit m_serving = 1'b0;
    int m_who     = 0;
    int m_taken   = 0;
    int m_ptr     = 0;

    task automatic release_grant();
        m_serving = 1'b0;
`ifndef BUFFER_RR_ARBITER_FIXED_PRIO_EN
        m_ptr = (m_who + 1) % N;
`endif
    endtask

    task automatic model_step();
        logic [N-1:0] exp_del;
        int start;
        bit found;
        exp_t e;
        exp_del = '0;
        if (mon_en) begin
            vectors++;
            if (grant_active !== m_serving) begin
                errors++;
                $display("FAIL grant_active: got %b expected %b at %0t", grant_active, m_serving, $time);
            end
        end
        if (!rst_n) begin
            m_serving = 1'b0;
            m_ptr     = 0;
        end else if (!m_serving) begin
`ifdef BUFFER_RR_ARBITER_FIXED_PRIO_EN
            start = 0;
`else
            start = m_ptr;
`endif
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && in_full[(start + k) % N]) begin
                    found     = 1'b1;
                    m_serving = 1'b1;
                    m_who     = (start + k) % N;
                    m_taken   = 0;
                end
            end
        end else if (!in_full[m_who]) begin
            release_grant();
        end else if (out_ready) begin
            exp_del[m_who] = 1'b1;
            e.src  = m_who;
            e.data = mem[m_who][head[m_who]];
            sb.push_back(e);
            m_taken++;
            if (m_taken == B) release_grant();
        end
        if (mon_en) begin
            vectors++;
            if (in_delete !== exp_del) begin
                errors++;
                $display("FAIL in_delete: got %b expected %b at %0t", in_delete, exp_del, $time);
            end
        end
    endtask

    // Monitor: every expected pop must surface as exactly one out_nd strobe on the following cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            vectors++;
            if (out_nd !== (sb.size() > 0)) begin
                errors++;
                $display("FAIL out_nd: got %b expected %b at %0t", out_nd, (sb.size() > 0), $time);
            end
            if (out_nd === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (out_data !== e.data || int'(out_src) != e.src) begin
                    errors++;
                    $display("FAIL out_word: got src %0d data %h expected src %0d data %h at %0t",
                             out_src, out_data, e.src, e.data, $time);
                end
            end else if (sb.size() > 0) begin
                void'(sb.pop_front());
            end
        end
    end

    task automatic cycle(input bit rdy, input bit rst);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            while (pend[i].size() > 0 && tail[i] < DEPTH - 1) begin
                mem[i][tail[i]] = pend[i].pop_front();
                tail[i]++;
            end
        end
        out_ready = rdy;
        rst_n     = !rst;
        #3;
        model_step();
    endtask

    initial begin
        cycle(1'b0, 1'b1);
        mon_en = 1'b1;
        cycle(1'b0, 1'b1);
        // Idle with nothing to drain.
        for (int c = 0; c < 10; c++) cycle(1'b1, 1'b0);
        // Single source with a burst boundary mid-stream.
        for (int k = 0; k < 6; k++) pend[2].push_back(32'hA0 + W'(k));
        for (int c = 0; c < 14; c++) cycle(1'b1, 1'b0);
        // One-word input at the pointer, then wrap to inputs 0 and 1.
        pend[3].push_back(32'hD3);
        for (int k = 0; k < 3; k++) begin
            pend[0].push_back(32'hC0 + W'(k));
            pend[1].push_back(32'hC8 + W'(k));
        end
        for (int c = 0; c < 16; c++) cycle(1'b1, 1'b0);
        // All inputs kept full.
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 24; k++) pend[i].push_back($urandom);
        for (int c = 0; c < 60; c++) cycle(1'b1, 1'b0);
        // Stall pattern while a grant is held.
        for (int c = 0; c < 8; c++) cycle(c[0], 1'b0);
        // Reset in the middle of whatever burst is running.
        cycle(1'b1, 1'b1);
        for (int c = 0; c < 20; c++) cycle(1'b1, 1'b0);
        // Randomized traffic, backpressure and occasional resets.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) pend[i].push_back($urandom);
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 99) == 0);
        end
        for (int c = 0; c < 200; c++) cycle(1'b1, 1'b0);
        @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending words expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
